// File: rtl/rr_prio_arbiter.sv
// rr_prio_arbiter: registered N-way request arbiter with runtime-selectable
// fixed-priority (highest index wins) or round-robin arbitration. A grant is
// held until the grantee releases, drops its request, or HOLD_MAX cycles pass.
//
// Ports:
//   clk             - clock, all state on rising edge
//   reset           - synchronous active-high reset
//   req_in          - request vector, bit i = requester i
//   rr_en_in        - 1 = round-robin, 0 = fixed priority
//   release_in      - current grantee finished (ignored when idle)
//   grant_out       - one-hot grant, zero when idle
//   grant_idx_out   - encoded grant index, zero when idle
//   grant_valid_out - a grant is active
//   timeout_out     - one-cycle pulse when a grant was ended purely by HOLD_MAX
module rr_prio_arbiter #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = $clog2(N_REQ),
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_in,
    input  logic             rr_en_in,
    input  logic             release_in,
    output logic [N_REQ-1:0] grant_out,
    output logic [IDX_W-1:0] grant_idx_out,
    output logic             grant_valid_out,
    output logic             timeout_out
);

    localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [IDX_W-1:0] ptr, ptr_nx;
    logic [N_REQ-1:0] grant_nx;
    logic [IDX_W-1:0] idx_nx;
    logic             vld_nx;
    logic             to_nx;

    logic [IDX_W-1:0] fp_win, rr_win, winner;
    logic             drop_rel, hit_to;

    // Winner selection. Round-robin priority is the descending distance from
    // ptr (mod N_REQ): the requester with the smallest distance wins.
    always_comb begin
        int best_d;
        int d;
        fp_win = '0;
        rr_win = '0;
        best_d = N_REQ;
        d      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_in[i]) begin
                fp_win = IDX_W'(i);
                d = int'(ptr) - i;
                if (d < 0) d = d + N_REQ;
                if (d < best_d) begin
                    best_d = d;
                    rr_win = IDX_W'(i);
                end
            end
        end
        winner = rr_en_in ? rr_win : fp_win;
    end

    // Release or request drop wins over timeout, so timeout_out only flags
    // grants ended purely by the hold counter.
    assign drop_rel = release_in || ~|(req_in & grant_out);
    assign hit_to   = (HOLD_MAX != 0) && (cnt == CNT_W'(HOLD_MAX));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        grant_nx = grant_out;
        idx_nx   = grant_idx_out;
        vld_nx   = grant_valid_out;
        to_nx    = 1'b0;
        case (state)
            IDLE: begin
                grant_nx = '0;
                idx_nx   = '0;
                vld_nx   = 1'b0;
                cnt_nx   = '0;
                if (|req_in) begin
                    state_nx = GRANT;
                    grant_nx = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                    idx_nx   = winner;
                    vld_nx   = 1'b1;
                    cnt_nx   = CNT_W'(1);
                    // last winner gets lowest round-robin priority next time
                    ptr_nx   = (winner == '0) ? IDX_W'(N_REQ - 1) : winner - 1'b1;
                end
            end
            GRANT: begin
                if (drop_rel || hit_to) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    idx_nx   = '0;
                    vld_nx   = 1'b0;
                    cnt_nx   = '0;
                    to_nx    = !drop_rel;
                end else if (HOLD_MAX != 0 && cnt != CNT_W'(HOLD_MAX)) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            ptr             <= IDX_W'(N_REQ - 1);
            grant_out       <= '0;
            grant_idx_out   <= '0;
            grant_valid_out <= 1'b0;
            timeout_out     <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            ptr             <= ptr_nx;
            grant_out       <= grant_nx;
            grant_idx_out   <= idx_nx;
            grant_valid_out <= vld_nx;
            timeout_out     <= to_nx;
        end
    end

endmodule
